// File: rtl/tmds_channel_decoder.sv
// Purpose: one TMDS receive channel; aligns words via control-token runs and decodes symbols.
// Latency: 2 cycles from TMDS to VD/CD/VDE; locked rises with the decoded Nth token.
// Backpressure: none; one symbol per cycle, outputs forced to 0 while not locked.
module tmds_channel_decoder #(
   parameter int MIN_CTRL_RUN  = 8,
   parameter int WINDOW        = 4096,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [9:0] TMDS,
   output logic       bitslip,
   output logic [3:0] slip_cnt,
   output logic       locked,
   output logic [7:0] VD,
   output logic [1:0] CD,
   output logic       VDE
);

   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int RW = $clog2(MIN_CTRL_RUN + 1);

   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_CTRL_RUN);
   localparam logic [RW-1:0] RUN_QUAL = RW'(MIN_CTRL_RUN - 1);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_SLIP,
      S_SETTLE,
      S_LOCKED
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] window_q, window_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [RW-1:0] run_q, run_d;
   logic [3:0]    slip_q, slip_d;

   logic [9:0] s1_sym;
   logic       s1_ctrl;
   logic [1:0] s1_cd;
   logic       in_ctrl;
   logic [1:0] in_cd;

   logic [7:0] dec_t;
   logic [7:0] dec_vd;
   logic [7:0] vd_q;
   logic [1:0] cd_q;
   logic       vde_q;
   logic       qualify;

   always_comb begin
      in_ctrl = 1'b1;
      in_cd   = 2'b00;
      case (TMDS)
         10'b1101010100: in_cd = 2'b00;
         10'b0010101011: in_cd = 2'b01;
         10'b0101010100: in_cd = 2'b10;
         10'b1010101011: in_cd = 2'b11;
         default:        in_ctrl = 1'b0;
      endcase
   end

   // Data symbols: undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      dec_t     = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
      dec_vd    = '0;
      dec_vd[0] = dec_t[0];
      for (int i = 1; i < 8; i++) begin
         dec_vd[i] = s1_sym[8] ? (dec_t[i] ^ dec_t[i-1]) : ~(dec_t[i] ^ dec_t[i-1]);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         s1_sym  <= '0;
         s1_ctrl <= 1'b0;
         s1_cd   <= '0;
         vd_q    <= '0;
         cd_q    <= '0;
         vde_q   <= 1'b0;
      end else begin
         s1_sym  <= TMDS;
         s1_ctrl <= in_ctrl;
         s1_cd   <= in_cd;
         if (s1_ctrl) begin
            vd_q  <= '0;
            cd_q  <= s1_cd;
            vde_q <= 1'b0;
         end else begin
            vd_q  <= dec_vd;
            vde_q <= 1'b1;
         end
      end
   end

   assign qualify = s1_ctrl && (run_q == RUN_QUAL);

   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      settle_d = settle_q;
      slip_d   = slip_q;
      run_d    = '0;

      // The run counter restarts after every slip so stale, pre-flush tokens never count.
      if ((state_q == S_SEARCH || state_q == S_LOCKED) && s1_ctrl) begin
         run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end

      case (state_q)
         S_SEARCH: begin
            window_d = window_q + 1'b1;
            if (qualify) begin
               state_d  = S_LOCKED;
               window_d = '0;
            end else if (window_q == WIN_LAST) begin
               state_d  = S_SLIP;
               window_d = '0;
            end
         end
         S_SLIP: begin
            slip_d   = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SET_LAST) begin
               state_d  = S_SEARCH;
               settle_d = '0;
               window_d = '0;
            end
         end
         S_LOCKED: begin
            window_d = window_q + 1'b1;
            if (qualify) begin
               window_d = '0;
            end else if (window_q == WIN_LAST) begin
               state_d  = S_SEARCH;
               window_d = '0;
            end
         end
         default: begin
            state_d  = S_SEARCH;
            window_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= S_SEARCH;
         window_q <= '0;
         settle_q <= '0;
         run_q    <= '0;
         slip_q   <= '0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         settle_q <= settle_d;
         run_q    <= run_d;
         slip_q   <= slip_d;
      end
   end

   assign locked   = (state_q == S_LOCKED);
   assign bitslip  = (state_q == S_SLIP);
   assign slip_cnt = slip_q;
   assign VD       = locked ? vd_q : 8'h00;
   assign CD       = locked ? cd_q : 2'b00;
   assign VDE      = locked & vde_q;

endmodule
